microstore_seq: RTL
===================

# microstore_seq

Writable, parametrised microprogram store with an integrated next-address sequencer for the ARM control unit. It replaces the fixed 55-bit × 64-entry combinational microstore lookup. The block holds microcode loaded through a write port and keeps a registered microinstruction (`uir`) plus microprogram counter (`upc`). Each cycle it selects the next address (increment, jump, conditional branch, decoder dispatch, subroutine call/return) using a bounded return-address stack.

## Interface
- `WORD_W`, 55: microinstruction width; must be ≥ `ADDR_W`+3
- `ADDR_W`, 6: store address width; depth = 2^`ADDR_W`
- `STACK_D`, 4: return-address stack depth (≥1)

- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `ld_en` in 1: microcode write enable
- `ld_addr` in `ADDR_W`: write address
- `ld_data` in `WORD_W`: write data
- `run` in 1: sequencer advance enable
- `cond` in 1: condition tested by conditional branches
- `dispatch_addr` in `ADDR_W`: instruction-decoder entry address
- `uir` out `WORD_W`: microinstruction register
- `upc` out `ADDR_W`: address of word held in `uir`
- `uir_valid` out 1: `uir` holds a fetched word
- `stack_ovf` out 1: sticky, call attempted with stack full
- `stack_unf` out 1: sticky, return attempted with stack empty

## Operation
- Sequencer fields of `uir`: NS = `uir[WORD_W-1 -: 3]`, TGT = `uir[ADDR_W-1:0]`; other bits pass through to the datapath.
- `next_addr` is combinational. If `uir_valid`=0, it is 0. Otherwise it is set by NS:
  - 000 INC: `upc`+1, modulo 2^`ADDR_W` (wrap from max to 0)
  - 001 JMP: TGT
  - 010 BRT: TGT if `cond`=1, else `upc`+1
  - 011 BRF: TGT if `cond`=0, else `upc`+1
  - 100 DISP: `dispatch_addr`
  - 101 CALL: push `upc`+1 (wrapped), then TGT
  - 110 RET: pop top of stack
  - 111 FETCH: 0
- On a clock edge with `run`=1: `upc`←`next_addr`, `uir`←store[`next_addr`], `uir_valid`←1, stack update applied.
- With `run`=0: `upc`, `uir`, `uir_valid`, stack and flags hold.
- Stack pointer `sp` ranges 0..`STACK_D`.
  - CALL with `sp`=`STACK_D`: no push, `stack_ovf`←1, jump to TGT still taken.
  - RET with `sp`=0: no pop, `stack_unf`←1, `next_addr`=0.
  - `stack_ovf` and `stack_unf` clear only on reset.
- Load port operates regardless of `run`. A write at edge N is visible to reads from edge N+1.
- Same-edge write/fetch to one address (`ld_en`=1, `ld_addr`=`next_addr`, `run`=1): `uir` captures `ld_data` (write-first bypass).
- Store contents are not reset. They are retained across `reset_n` and undefined until loaded.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release) drives: `uir`=0, `upc`=0, `uir_valid`=0, `sp`=0, `stack_ovf`=0, `stack_unf`=0.
- First `run` edge after reset fetches store[0]. `upc` stays 0 and `uir_valid` goes to 1.
- Fetch latency is one cycle. After each advancing edge, `uir` equals store[`upc`] as written before that edge, or the bypassed `ld_data`.
- `cond` and `dispatch_addr` are sampled only at the advancing edge and must be stable during the setup window.
- Reset asserted mid-program, including with a non-empty stack, discards the stack and the in-flight word immediately.

## Test plan
- Load 0:INC, 1:INC, 2:JMP 0. Reset, then `run`=1 → `upc` 0,1,2,0,1; `uir_valid` rises on the first edge.
- Word 3 = BRT 10. With `cond`=1 → next `upc`=10; with `cond`=0 → next `upc`=4. Repeat with BRF and verify the inverse.
- Word 5 = CALL 20, word 20 = RET → `upc` 5,20,6; `sp` returns to 0. Additionally, INC at address 63 → `upc` 0.
- `STACK_D`=4 with 5 nested CALLs:
  - 5th CALL sets `stack_ovf`=1 and still jumps to its target.
  - 4 RETs unwind correctly; the 5th RET sets `stack_unf`=1 and `upc`=0.
  - Both flags stay set until reset.
- DISP word with `dispatch_addr`=0x2A, while `ld_en` writes `ld_data`=0x155 to 0x2A on the same edge → `upc`=0x2A, `uir`=0x155.
- Run with `sp`=2, then assert `reset_n`=0 mid-cycle:
  - Outputs go to reset values at once.
  - After release, the first `run` edge yields `upc`=0 and `uir`=the previously loaded store[0].
- `run`=0 for 3 cycles mid-program → `upc` and `uir` hold.

Source files
------------

// File: rtl/microstore_seq.sv
// microstore_seq
//   Writable microprogram store with a registered microinstruction and an
//   integrated next-address sequencer (increment, jump, conditional branch,
//   decoder dispatch, subroutine call/return through a bounded stack).
//
// Parameters
//   WORD_W   microinstruction width (>= ADDR_W+3)
//   ADDR_W   store address width, depth = 2**ADDR_W
//   STACK_D  return-address stack depth (>= 1)
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   ld_en          microcode write enable
//   ld_addr        microcode write address
//   ld_data        microcode write data
//   run            sequencer advance enable
//   cond           condition for BRT/BRF, sampled at the advancing edge
//   dispatch_addr  decoder entry address for DISP
//   uir            microinstruction register
//   upc            address of the word held in uir
//   uir_valid      uir holds a fetched word
//   stack_ovf      sticky: CALL seen with the stack full
//   stack_unf      sticky: RET seen with the stack empty

module microstore_seq #(
    parameter int WORD_W  = 55,
    parameter int ADDR_W  = 6,
    parameter int STACK_D = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              run,
    input  logic              cond,
    input  logic [ADDR_W-1:0] dispatch_addr,
    output logic [WORD_W-1:0] uir,
    output logic [ADDR_W-1:0] upc,
    output logic              uir_valid,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int SI_W  = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic [2:0] {
        NS_INC   = 3'b000,
        NS_JMP   = 3'b001,
        NS_BRT   = 3'b010,
        NS_BRF   = 3'b011,
        NS_DISP  = 3'b100,
        NS_CALL  = 3'b101,
        NS_RET   = 3'b110,
        NS_FETCH = 3'b111
    } ns_t;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] stk [STACK_D];
    logic [SP_W-1:0]   sp;

    ns_t               ns;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] upc_inc;
    logic              stk_full;
    logic              stk_empty;
    logic [SI_W-1:0]   push_idx;
    logic [SI_W-1:0]   top_idx;
    logic [ADDR_W-1:0] next_addr;
    logic              do_push;
    logic              do_pop;
    logic              set_ovf;
    logic              set_unf;
    logic [WORD_W-1:0] fetch_word;

    assign ns        = ns_t'(uir[WORD_W-1 -: 3]);
    assign tgt       = uir[ADDR_W-1:0];
    assign upc_inc   = upc + ADDR_W'(1);
    assign stk_full  = (sp == SP_W'(STACK_D));
    assign stk_empty = (sp == '0);
    // push_idx is only used while the stack is not full, and top_idx only
    // while it is not empty, so the truncation never selects a bad entry.
    assign push_idx  = SI_W'(sp);
    assign top_idx   = SI_W'(sp - SP_W'(1));

    always_comb begin
        next_addr = '0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (uir_valid) begin
            case (ns)
                NS_INC:   next_addr = upc_inc;
                NS_JMP:   next_addr = tgt;
                NS_BRT:   next_addr = cond ? tgt : upc_inc;
                NS_BRF:   next_addr = cond ? upc_inc : tgt;
                NS_DISP:  next_addr = dispatch_addr;
                NS_CALL: begin
                    // The jump is taken even when the return address is dropped.
                    next_addr = tgt;
                    do_push   = ~stk_full;
                    set_ovf   = stk_full;
                end
                NS_RET: begin
                    next_addr = stk_empty ? '0 : stk[top_idx];
                    do_pop    = ~stk_empty;
                    set_unf   = stk_empty;
                end
                NS_FETCH: next_addr = '0;
                default:  next_addr = '0;
            endcase
        end
    end

    // Write-first: a load to the address being fetched lands directly in uir.
    assign fetch_word = (ld_en && (ld_addr == next_addr)) ? ld_data : mem[next_addr];

    // Store contents survive reset; only the sequencer state is cleared.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Stack entries need no reset: sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (run && do_push) begin
            stk[push_idx] <= upc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir       <= '0;
            upc       <= '0;
            uir_valid <= 1'b0;
            sp        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (run) begin
            uir       <= fetch_word;
            upc       <= next_addr;
            uir_valid <= 1'b1;
            if (do_push) begin
                sp <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp - SP_W'(1);
            end
            stack_ovf <= stack_ovf | set_ovf;
            stack_unf <= stack_unf | set_unf;
        end
    end

endmodule
